// File: rtl/move_scheduler.sv
// Purpose : queues debounced button presses and replays them as one-cycle move pulses spaced by a settle gap.
// Latency : press sampled at edge k from idle/empty -> move pulse high from edge k+1 to k+2.
// Backpressure: presses arriving at a full FIFO are dropped and counted, unless a pop frees a slot in that same cycle.
module move_scheduler #(
    parameter int SETTLE_CYCLES = 80,
    parameter int QUEUE_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       btn_up,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       btn_left,
    output logic       move_up,
    output logic       move_right,
    output logic       move_down,
    output logic       move_left,
    output logic       busy,
    output logic       queue_full,
    output logic [7:0] drop_count
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam int SC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SC_W-1:0]  SETTLE_LOAD = SC_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2
    } state_t;

    // Bit order everywhere: [0]=up, [1]=right, [2]=down, [3]=left (matches the 2-bit code).
    logic [3:0]       btn_lvl;
    logic [3:0]       btn_prev_q;
    logic [3:0]       rise;
    logic             acc_vld;
    logic [1:0]       acc_code;
    logic [2:0]       n_rise;
    logic [2:0]       drop_inc;
    logic [8:0]       drop_sum;
    logic [7:0]       drop_d, drop_q;

    logic [1:0]       mem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             fifo_empty, fifo_full;
    logic             push, pop;
    logic [1:0]       head_code;

    state_t           state_q, state_d;
    logic [SC_W-1:0]  settle_q, settle_d;
    logic [3:0]       move_d, move_q;

    assign btn_lvl    = {btn_left, btn_down, btn_right, btn_up};
    assign rise       = btn_lvl & ~btn_prev_q;
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == DEPTH_CNT);
    assign head_code  = mem_q[rd_ptr_q];

    // Previous button levels; reset to 1 so a button held through reset is not a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev_q <= 4'b1111;
        end else begin
            btn_prev_q <= btn_lvl;
        end
    end

    // Fixed-priority pick among simultaneous rising edges: up > right > down > left.
    always_comb begin
        acc_vld  = 1'b1;
        acc_code = 2'd0;
        if (rise[0]) begin
            acc_code = 2'd0;
        end else if (rise[1]) begin
            acc_code = 2'd1;
        end else if (rise[2]) begin
            acc_code = 2'd2;
        end else if (rise[3]) begin
            acc_code = 2'd3;
        end else begin
            acc_vld = 1'b0;
        end
    end

    assign n_rise = 3'(rise[0]) + 3'(rise[1]) + 3'(rise[2]) + 3'(rise[3]);
    // A pop in the same cycle frees a slot, so a full FIFO only rejects when nothing leaves.
    assign push   = ena && acc_vld && (!fifo_full || pop);

    // Discarded presses: losers of the priority pick plus a winner rejected by a full FIFO.
    always_comb begin
        drop_inc = n_rise - 3'(acc_vld) + 3'(acc_vld && fifo_full && !pop);
        drop_sum = {1'b0, drop_q} + {6'b0, drop_inc};
        drop_d   = drop_q;
        if (ena) begin
            drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

    // Saturating drop counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 8'd0;
        end else begin
            drop_q <= drop_d;
        end
    end

    // Occupancy next-state from simultaneous push/pop.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // FIFO pointers and occupancy; disabling the scheduler flushes the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else if (!ena) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= acc_code;
        end
    end

    // FSM state and settle counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
        end
    end

    // FSM next state: IDLE waits for work, ISSUE lasts one cycle, SETTLE counts down to 0.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        case (state_q)
            ST_IDLE: begin
                if (ena && !fifo_empty) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d  = ST_SETTLE;
                settle_d = SETTLE_LOAD;
            end
            ST_SETTLE: begin
                if (settle_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    settle_d = settle_q - 1'b1;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                settle_d = '0;
            end
        endcase
    end

    // FSM outputs: pop the head on leaving IDLE and stage its one-hot move for the ISSUE cycle.
    always_comb begin
        pop    = (state_q == ST_IDLE) && ena && !fifo_empty;
        move_d = pop ? 4'(4'b0001 << head_code) : 4'b0000;
        busy   = (state_q != ST_IDLE) || !fifo_empty;
    end

    // Registered move pulses, high exactly during the ISSUE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            move_q <= 4'b0000;
        end else begin
            move_q <= move_d;
        end
    end

    assign move_up    = move_q[0];
    assign move_right = move_q[1];
    assign move_down  = move_q[2];
    assign move_left  = move_q[3];
    assign queue_full = fifo_full;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_move_scheduler.sv
module tb_move_scheduler;

    localparam int S = 8;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       btn_up, btn_right, btn_down, btn_left;
    logic       move_up, move_right, move_down, move_left;
    logic       busy, queue_full;
    logic [7:0] drop_count;
    logic [3:0] mv_now;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int multi_hot = 0;
    int pulse_cyc[$];
    int pulse_code[$];

    typedef struct {
        logic [3:0] btn;
        logic       en;
        logic [3:0] mv;
        logic       busy;
        logic       full;
        logic [7:0] drop;
    } vec_t;

    vec_t vecs[$];

    move_scheduler #(.SETTLE_CYCLES(S), .QUEUE_DEPTH(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ena        (ena),
        .btn_up     (btn_up),
        .btn_right  (btn_right),
        .btn_down   (btn_down),
        .btn_left   (btn_left),
        .move_up    (move_up),
        .move_right (move_right),
        .move_down  (move_down),
        .move_left  (move_left),
        .busy       (busy),
        .queue_full (queue_full),
        .drop_count (drop_count)
    );

    assign mv_now = {move_left, move_down, move_right, move_up};

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Records every cycle in which a move output is high.
    always @(negedge clk) begin
        if (mv_now != 4'b0000) begin
            pulse_cyc.push_back(cyc);
            if (mv_now[0])      pulse_code.push_back(0);
            else if (mv_now[1]) pulse_code.push_back(1);
            else if (mv_now[2]) pulse_code.push_back(2);
            else                pulse_code.push_back(3);
            if ($countones(mv_now) != 1) multi_hot++;
        end
    end

    function automatic void chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void add(input logic [3:0] b, input logic en, input logic [3:0] mv,
                                input logic bz, input logic fl, input logic [7:0] dr);
        vec_t v;
        v.btn = b; v.en = en; v.mv = mv; v.busy = bz; v.full = fl; v.drop = dr;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic [3:0] b, input logic en);
        {btn_left, btn_down, btn_right, btn_up} = b;
        ena = en;
    endtask

    task automatic step(input logic [3:0] b, input logic en);
        drive(b, en);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] b);
        drive(b, 1'b1);
        rst_n = 1'b0;
        pulse_cyc.delete();
        pulse_code.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_pulses(input string name, input int n, input int bound);
        for (int i = 0; i < bound && pulse_code.size() < n; i++) step(4'b0000, 1'b1);
        chk(name, pulse_code.size(), n);
    endtask

    initial begin
        int t;
        int exp_codes[6];

        // Directed per-cycle vectors (bit0=up, 1=right, 2=down, 3=left).
        add(4'b0000, 1, 4'b0000, 0, 0, 0);
        add(4'b1000, 1, 4'b0000, 1, 0, 0);            // left press
        add(4'b1000, 1, 4'b1000, 1, 0, 0);            // ISSUE: move_left
        add(4'b0000, 1, 4'b0000, 1, 0, 0);            // SETTLE load
        for (int i = 0; i < S - 1; i++) add(4'b0000, 1, 4'b0000, 1, 0, 0);
        add(4'b0000, 1, 4'b0000, 0, 0, 0);            // back to IDLE
        add(4'b0101, 1, 4'b0000, 1, 0, 1);            // up+down together: down dropped
        add(4'b0101, 1, 4'b0001, 1, 0, 1);            // move_up
        add(4'b0000, 1, 4'b0000, 1, 0, 1);
        for (int i = 0; i < S - 1; i++) add(4'b0000, 1, 4'b0000, 1, 0, 1);
        add(4'b0000, 1, 4'b0000, 0, 0, 1);
        add(4'b0010, 1, 4'b0000, 1, 0, 1);            // right press, then held
        add(4'b0010, 1, 4'b0010, 1, 0, 1);
        add(4'b0010, 1, 4'b0000, 1, 0, 1);
        for (int i = 0; i < S - 1; i++) add(4'b0010, 1, 4'b0000, 1, 0, 1);
        add(4'b0010, 1, 4'b0000, 0, 0, 1);
        add(4'b0010, 1, 4'b0000, 0, 0, 1);            // held: no second press
        add(4'b0010, 1, 4'b0000, 0, 0, 1);

        // Reset values with all buttons held.
        drive(4'b1111, 1'b1);
        rst_n = 1'b0;
        #3;
        chk("rst_move", mv_now, 0);
        chk("rst_busy", busy, 0);
        chk("rst_full", queue_full, 0);
        chk("rst_drop", drop_count, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].btn, vecs[i].en);
            chk($sformatf("vec%0d_move", i), mv_now, vecs[i].mv);
            chk($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
            chk($sformatf("vec%0d_full", i), queue_full, vecs[i].full);
            chk($sformatf("vec%0d_drop", i), drop_count, vecs[i].drop);
        end

        // Six presses during SETTLE, then push+pop while full.
        do_reset(4'b0000);
        step(4'b0000, 1);
        step(4'b0100, 1);
        step(4'b0000, 1);
        step(4'b0000, 1);
        step(4'b0001, 1);
        step(4'b0010, 1);
        step(4'b0100, 1);
        step(4'b1000, 1);
        chk("a_full_at4", queue_full, 1);
        chk("a_drop_at4", drop_count, 0);
        step(4'b0001, 1);
        step(4'b0010, 1);
        chk("a_full_at6", queue_full, 1);
        chk("a_drop_at6", drop_count, 2);
        step(4'b0000, 1);
        step(4'b0000, 1);
        step(4'b0100, 1);
        chk("a_pushpop_move", mv_now, 4'b0001);
        chk("a_pushpop_full", queue_full, 1);
        chk("a_pushpop_drop", drop_count, 2);
        wait_pulses("a_pulse_count", 6, 200);
        exp_codes = '{2, 0, 1, 2, 3, 2};
        for (int i = 0; i < 6 && i < pulse_code.size(); i++)
            chk($sformatf("a_code%0d", i), pulse_code[i], exp_codes[i]);
        for (int i = 1; i < 6 && i < pulse_cyc.size(); i++)
            chk($sformatf("a_spacing%0d", i), pulse_cyc[i] - pulse_cyc[i-1], S + 2);
        repeat (20) step(4'b0000, 1);
        chk("a_no_extra", pulse_code.size(), 6);
        chk("a_end_busy", busy, 0);
        chk("a_end_full", queue_full, 0);

        // Three queued moves, disable during SETTLE.
        do_reset(4'b0000);
        step(4'b0000, 1);
        step(4'b0001, 1);
        step(4'b0010, 1);
        step(4'b0100, 1);
        step(4'b1000, 1);
        chk("b_busy_pre", busy, 1);
        chk("b_pulses_pre", pulse_code.size(), 1);
        step(4'b0000, 0);
        chk("b_busy_settling", busy, 1);
        repeat (5) step(4'b0000, 0);
        repeat (6) step(4'b0001, 0);
        chk("b_busy_off", busy, 0);
        chk("b_full_off", queue_full, 0);
        chk("b_drop_off", drop_count, 0);
        repeat (5) step(4'b0001, 1);
        chk("b_pulses_post", pulse_code.size(), 1);
        chk("b_busy_post", busy, 0);

        // Right held through reset release.
        do_reset(4'b0010);
        repeat (5) step(4'b0010, 1);
        chk("c_no_pulse", pulse_code.size(), 0);
        chk("c_busy_held", busy, 0);
        step(4'b0000, 1);
        step(4'b0010, 1);
        chk("c_busy_press", busy, 1);
        wait_pulses("c_pulse", 1, 30);
        if (pulse_code.size() > 0) chk("c_code", pulse_code[0], 1);
        repeat (15) step(4'b0000, 1);
        chk("c_single", pulse_code.size(), 1);

        // Asynchronous reset mid-SETTLE with two moves queued.
        do_reset(4'b0000);
        step(4'b0000, 1);
        step(4'b1001, 1);
        step(4'b0010, 1);
        step(4'b0100, 1);
        step(4'b0000, 1);
        chk("d_busy_pre", busy, 1);
        chk("d_drop_pre", drop_count, 1);
        #3;
        t = cyc;
        rst_n = 1'b0;
        #1;
        chk("d_no_edge", cyc, t);
        chk("d_move", mv_now, 0);
        chk("d_busy", busy, 0);
        chk("d_full", queue_full, 0);
        chk("d_drop", drop_count, 0);
        pulse_cyc.delete();
        pulse_code.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) step(4'b0000, 1);
        chk("d_no_pulse", pulse_code.size(), 0);
        chk("d_busy_after", busy, 0);

        // Drop counter saturation.
        do_reset(4'b0000);
        step(4'b0000, 1);
        step(4'b1111, 1);
        chk("e_drop_three", drop_count, 3);
        step(4'b0000, 1);
        for (int i = 0; i < 100; i++) begin
            step(4'b1111, 1);
            step(4'b0000, 1);
        end
        chk("e_drop_sat", drop_count, 255);

        chk("one_hot", multi_hot, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
